// File: rtl/serial_frame_pkg.sv
// Shared frame constants and controller state type for the serial frame transmitter
// and the matching receiver controller.
package serial_frame_pkg;

    localparam int unsigned PRE_W  = 4;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned DATA_W = 16;

    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1101;

    // Index width for a vector of n bits (at least one bit).
    function automatic int unsigned idx_w(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned CNT_W = max3(idx_w(PRE_W), LEN_W, idx_w(DATA_W));

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StPre  = 3'd2,
        StLen  = 3'd3,
        StPay  = 3'd4,
        StDone = 3'd5
    } tx_state_e;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Host-side bundle of the serial frame transmitter: request/payload in, status and line out.
interface serial_frame_tx_if;
    import serial_frame_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              serial_out;
    logic              done;

    modport master (
        output start, len, data,
        input  ready, busy, serial_out, done
    );

    modport slave (
        input  start, len, data,
        output ready, busy, serial_out, done
    );

endinterface

// File: rtl/serial_frame_tx_ctrl.sv
// Frame sequencing FSM: walks IDLE -> LOAD -> PRE -> LEN -> PAY -> DONE driven by the
// datapath's bit counter.
module serial_frame_tx_ctrl
    import serial_frame_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      start_i,
    input  logic      cnt_zero_i,
    input  logic      len_zero_i,
    output tx_state_e state_o,
    output logic      ready_o,
    output logic      busy_o
);

    tx_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) state_d = StLoad;
            end
            StLoad: begin
                if (!start_i) state_d = StPre;
            end
            StPre: begin
                busy_o = 1'b1;
                if (cnt_zero_i) state_d = StLen;
            end
            StLen: begin
                busy_o = 1'b1;
                if (cnt_zero_i) state_d = len_zero_i ? StDone : StPay;
            end
            StPay: begin
                busy_o = 1'b1;
                if (cnt_zero_i) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter top: captures host payload, shifts out preamble, length field
// and payload MSB first on a registered line, then pulses done.
module serial_frame_tx
    import serial_frame_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    serial_frame_tx_if.slave bus_io
);

    localparam int unsigned PreIdxW  = idx_w(PRE_W);
    localparam int unsigned LenIdxW  = idx_w(LEN_W);
    localparam int unsigned DataIdxW = idx_w(DATA_W);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    tx_state_e         state;
    logic [LEN_W-1:0]  len_q, len_d, len_clamp;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              cnt_zero, len_zero, capture;

    serial_frame_tx_ctrl u_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (bus_io.start),
        .cnt_zero_i (cnt_zero),
        .len_zero_i (len_zero),
        .state_o    (state),
        .ready_o    (bus_io.ready),
        .busy_o     (bus_io.busy)
    );

    assign cnt_zero  = (cnt_q == '0);
    assign len_zero  = (len_q == '0);
    assign capture   = bus_io.start && ((state == StIdle) || (state == StLoad));
    // Payload register only holds DATA_W bits, so longer requests are cut to a full word.
    assign len_clamp = (bus_io.len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus_io.len;

    always_comb begin
        len_d    = len_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        serial_d = 1'b0;
        done_d   = 1'b0;
        if (capture) begin
            len_d  = len_clamp;
            data_d = bus_io.data;
        end
        case (state)
            StLoad: begin
                if (!bus_io.start) cnt_d = CNT_W'(PRE_W - 1);
            end
            StPre: begin
                serial_d = PREAMBLE[cnt_q[PreIdxW-1:0]];
                cnt_d    = cnt_zero ? CNT_W'(LEN_W - 1) : cnt_q - CntOne;
            end
            StLen: begin
                serial_d = len_q[cnt_q[LenIdxW-1:0]];
                if (cnt_zero) begin
                    cnt_d = len_zero ? '0 : CNT_W'(len_q) - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StPay: begin
                serial_d = data_q[cnt_q[DataIdxW-1:0]];
                cnt_d    = cnt_zero ? '0 : cnt_q - CntOne;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            len_q    <= len_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign bus_io.serial_out = serial_q;
    assign bus_io.done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: stimulus queues hand-written frame strings,
// a negedge monitor pops one token per line bit or done pulse.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_frame_tx_if bus ();

    serial_frame_tx dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int bits_seen = 0;
    int exp_q[$];  // 0/1 = line bit, 2 = done pulse

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "1") exp_q.push_back(1);
            else if (s[i] == "0") exp_q.push_back(0);
            else exp_q.push_back(2);
        end
    endtask

    task automatic send(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data);
        @(negedge clk);
        bus.len   = len;
        bus.data  = data;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (bits_seen < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_bits_timeout", int'(n >= 200), 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", int'(n >= 300), 0);
    endtask

    // Monitor: a line bit is due whenever the FSM was busy on the previous sample.
    initial begin : monitor
        logic busy_d1;
        int   e;
        busy_d1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_d1 = 1'b0;
            end else begin
                if (busy_d1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit: got %0b with nothing expected", bus.serial_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bit", int'(bus.serial_out), e);
                    end
                    bits_seen++;
                end
                if (bus.done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 with nothing expected");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_pulse", 2, e);
                    end
                    check("line_at_done", int'(bus.serial_out), 0);
                end else if (!busy_d1) begin
                    check("idle_line", int'(bus.serial_out), 0);
                end
                busy_d1 = bus.busy;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        bus.start = 1'b0;
        bus.len   = '0;
        bus.data  = '0;
        #1 rst_n = 1'b0;

        // Reset with random host activity
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bus.len   = LEN_W'($urandom);
            bus.data  = DATA_W'($urandom);
            #1;
            check("rst_ready", int'(bus.ready), 1);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_serial", int'(bus.serial_out), 0);
            check("rst_done", int'(bus.done), 0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic frame
        push_str("11010010110110D");
        send(5'd5, 16'h0016);
        wait_drain();

        // Zero length
        push_str("110100000D");
        send(5'd0, 16'hFFFF);
        wait_drain();

        // Clamp to full payload
        push_str({"1101", "10000", "1010010111000011", "D"});
        send(5'd31, 16'hA5C3);
        wait_drain();

        // Held start with recapture, ignored mid-frame start, start held through DONE
        push_str({"1101", "01000", "01011010", "D"});
        base = bits_seen;
        @(negedge clk);
        bus.len = 5'd3; bus.data = 16'h00FF; bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.len = 5'd8; bus.data = 16'h005A;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_bits(base + 6);
        bus.len = 5'd31; bus.data = 16'hFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_bits(base + 15);
        push_str({"1101", "00100", "1001", "D"});
        bus.len = 5'd4; bus.data = 16'h0009; bus.start = 1'b1;
        begin
            int n = 0;
            while (bus.ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("ready_timeout", int'(n >= 100), 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();

        // Async reset during payload, then a clean frame
        push_str({"1101", "00110", "101"});
        base = bits_seen;
        send(5'd6, 16'h002D);
        wait_bits(base + 12);
        rst_n = 1'b0;
        #1;
        check("abort_serial", int'(bus.serial_out), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_ready", int'(bus.ready), 1);
        check("abort_done", int'(bus.done), 0);
        check("abort_queue", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        push_str({"1101", "00010", "10", "D"});
        send(5'd2, 16'h0002);
        wait_drain();
        repeat (4) @(negedge clk);
        check("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
